// File: rtl/ram_sync_ctrl_if.sv
// Request/response bus for ram_sync_ctrl.
// The master issues valid/ready requests and receives registered read responses.
interface ram_sync_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    localparam int BE_W = DATA_W / 8;

    logic              reqValid;
    logic              reqReady;
    logic              RW;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataIn;
    logic [BE_W-1:0]   byteEn;
    logic [DATA_W-1:0] dataOut;
    logic              respValid;
    logic              respErr;

    modport master (
        output reqValid, RW, address, dataIn, byteEn,
        input  reqReady, dataOut, respValid, respErr
    );

    modport slave (
        input  reqValid, RW, address, dataIn, byteEn,
        output reqReady, dataOut, respValid, respErr
    );
endinterface

// File: rtl/ram_sync_ctrl.sv
// Synchronous single-port RAM with byte enables, 1-cycle registered
// reads and a word-per-cycle clear engine.
module ram_sync_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = (1 << ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    ram_sync_ctrl_if.slave    bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic in_range;
    logic acc;
    logic wr_acc;
    logic rd_acc;

    assign in_range = {1'b0, bus.address} < DEPTH_L;
    assign acc      = bus.reqValid && bus.reqReady;
    assign wr_acc   = acc && bus.RW;
    assign rd_acc   = acc && !bus.RW;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        busy         = 1'b0;
        bus.reqReady = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.reqReady = !clear;
                if (clear) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage is deliberately not reset; only writes and CLEAR touch it.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.byteEn[i]) begin
                    mem[bus.address][8*i +: 8] <= bus.dataIn[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dataOut   <= '0;
            bus.respValid <= 1'b0;
            bus.respErr   <= 1'b0;
        end else begin
            bus.respValid <= rd_acc;
            if (rd_acc) begin
                bus.dataOut <= in_range ? mem[bus.address] : '0;
                bus.respErr <= !in_range;
            end
        end
    end
endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Directed bench for ram_sync_ctrl: a full-depth instance (16 words)
// and a partial-depth instance (12 words) share one request driver.
module tb_ram_sync_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_a = 1'b0;
    logic        clear_b = 1'b0;
    logic        busy_a;
    logic        busy_b;

    logic        sel = 1'b0;
    logic        rv = 1'b0;
    logic        rw = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  be = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_sync_ctrl_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
    ram_sync_ctrl_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

    assign bus_a.reqValid = rv && !sel;
    assign bus_a.RW       = rw;
    assign bus_a.address  = addr;
    assign bus_a.dataIn   = din;
    assign bus_a.byteEn   = be;
    assign bus_b.reqValid = rv && sel;
    assign bus_b.RW       = rw;
    assign bus_b.address  = addr;
    assign bus_b.dataIn   = din;
    assign bus_b.byteEn   = be;

    ram_sync_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_a),
        .busy  (busy_a),
        .bus   (bus_a)
    );

    ram_sync_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(12)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_b),
        .busy  (busy_b),
        .bus   (bus_b)
    );

    wire        rdy  = sel ? bus_b.reqReady  : bus_a.reqReady;
    wire        rval = sel ? bus_b.respValid : bus_a.respValid;
    wire        rerr = sel ? bus_b.respErr   : bus_a.respErr;
    wire [31:0] rdat = sel ? bus_b.dataOut   : bus_a.dataOut;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request; returns 1ns after the accepting edge.
    task automatic req(input logic s, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        int n;
        @(negedge clk);
        sel  = s;
        rw   = w;
        addr = a;
        din  = d;
        be   = b;
        rv   = 1'b1;
        n    = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            check("req_timeout", {31'b0, rdy}, 32'd1);
        end
        @(posedge clk);
        #1;
        rv = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic s, input logic [3:0] a,
                          input logic [31:0] exp, input logic err);
        req(s, 1'b0, a, '0, '0);
        check({tag, "_vld"}, {31'b0, rval}, 32'd1);
        check({tag, "_err"}, {31'b0, rerr}, {31'b0, err});
        check({tag, "_dat"}, rdat, exp);
    endtask

    initial begin
        int busy_cnt;
        int acc_edge;
        logic rdy_pre;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("b_busy_idle", {31'b0, busy_b}, 32'd0);

        // Full-word write, then read back
        req(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        rd_chk("rd3", 1'b0, 4'd3, 32'hDEADBEEF, 1'b0);

        // Asynchronous reset mid-cycle, while a response is showing
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_dout", bus_a.dataOut, 32'h0);
        check("rst_rvld", {31'b0, bus_a.respValid}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_rdy",  {31'b0, bus_a.reqReady}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Memory survives reset
        rd_chk("rd3_post_rst", 1'b0, 4'd3, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        #1;
        check("rvld_pulse", {31'b0, bus_a.respValid}, 32'd0);
        check("dout_hold", bus_a.dataOut, 32'hDEADBEEF);

        // Byte enables
        req(1'b0, 1'b1, 4'd3, 32'h11223344, 4'b0101);
        rd_chk("be0101", 1'b0, 4'd3, 32'hDE22BE44, 1'b0);
        req(1'b0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000);
        rd_chk("be0000", 1'b0, 4'd3, 32'hDE22BE44, 1'b0);

        // Clear colliding with a pending read of addr 3
        req(1'b0, 1'b1, 4'd15, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        sel     = 1'b0;
        rw      = 1'b0;
        addr    = 4'd3;
        rv      = 1'b1;
        clear_a = 1'b1;
        #1;
        check("clr_rdy", {31'b0, bus_a.reqReady}, 32'd0);
        @(posedge clk);
        #1;
        clear_a  = 1'b0;
        busy_cnt = 0;
        acc_edge = 0;
        for (int k = 1; k <= 40 && acc_edge == 0; k++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            rdy_pre = bus_a.reqReady;
            @(posedge clk);
            #1;
            if (rdy_pre) acc_edge = k;
        end
        rv = 1'b0;
        check("clr_busy_cycles", busy_cnt, 32'd16);
        check("clr_acc_edge", acc_edge, 32'd17);
        check("clr_rd3_vld", {31'b0, bus_a.respValid}, 32'd1);
        check("clr_rd3_dat", bus_a.dataOut, 32'h0);
        rd_chk("clr_rd15", 1'b0, 4'd15, 32'h0, 1'b0);

        // Partial-depth instance: out-of-range handling
        req(1'b1, 1'b1, 4'd13, 32'h13131313, 4'hF);
        rd_chk("b_rd13", 1'b1, 4'd13, 32'h0, 1'b1);
        rd_chk("b_rd12", 1'b1, 4'd12, 32'h0, 1'b1);
        req(1'b1, 1'b1, 4'd11, 32'hCAFEF00D, 4'hF);
        rd_chk("b_rd11", 1'b1, 4'd11, 32'hCAFEF00D, 1'b0);

        // Reset during CLEAR after five words
        req(1'b0, 1'b1, 4'd2, 32'h22222222, 4'hF);
        req(1'b0, 1'b1, 4'd5, 32'h55555555, 4'hF);
        req(1'b0, 1'b1, 4'd8, 32'h88888888, 4'hF);
        @(negedge clk);
        clear_a = 1'b1;
        @(posedge clk);
        #1;
        clear_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("abort_rd0", 1'b0, 4'd0, 32'h0, 1'b0);
        rd_chk("abort_rd2", 1'b0, 4'd2, 32'h0, 1'b0);
        rd_chk("abort_rd5", 1'b0, 4'd5, 32'h55555555, 1'b0);
        rd_chk("abort_rd8", 1'b0, 4'd8, 32'h88888888, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
